// File: rtl/ramb16_s18_arb.sv
// Two-requester arbiter in front of a 1Kx18 single-port block RAM, with a
// background clear sweep that writes CLR_VAL to every word.
module ramb16_s18_arb #(
    parameter logic [17:0] CLR_VAL   = 18'h0,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CLR,
    output logic        BUSY,
    input  logic        A_REQ,
    input  logic        A_WE,
    input  logic [9:0]  A_ADDR,
    input  logic [15:0] A_DI,
    input  logic [1:0]  A_DIP,
    output logic        A_GNT,
    output logic        A_RVALID,
    output logic [15:0] A_DO,
    output logic [1:0]  A_DOP,
    input  logic        B_REQ,
    input  logic        B_WE,
    input  logic [9:0]  B_ADDR,
    input  logic [15:0] B_DI,
    input  logic [1:0]  B_DIP,
    output logic        B_GNT,
    output logic        B_RVALID,
    output logic [15:0] B_DO,
    output logic [1:0]  B_DOP,
    output logic        RAM_EN,
    output logic        RAM_WE,
    output logic        RAM_SSR,
    output logic [9:0]  RAM_ADDR,
    output logic [15:0] RAM_DI,
    output logic [1:0]  RAM_DIP,
    input  logic [15:0] RAM_DO,
    input  logic [1:0]  RAM_DOP
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [9:0]  clr_cnt;
    logic        last_b;
    logic        run;
    logic        vld_a_p1, vld_b_p1;
    logic        gnt_a, gnt_b;

    // run holds grants off from reset until the first edge after release,
    // so every output sits at its reset value during that window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            last_b   <= 1'b1;
            run      <= 1'b0;
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
        end else begin
            run      <= 1'b1;
            state    <= state_nxt;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 10'd1;
            if (gnt_a || gnt_b)
                last_b <= gnt_b;
            vld_a_p1 <= gnt_a & ~A_WE;
            vld_b_p1 <= gnt_b & ~B_WE;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        RAM_EN    = 1'b0;
        RAM_WE    = 1'b0;
        RAM_ADDR  = '0;
        RAM_DI    = '0;
        RAM_DIP   = '0;
        case (state)
            IDLE: begin
                if (run) begin
                    if (CLR) begin
                        state_nxt = CLEAR;
                    end else begin
                        gnt_a = A_REQ & (~B_REQ | FIXED_PRI | last_b);
                        gnt_b = B_REQ & ~gnt_a;
                    end
                end
            end
            CLEAR: begin
                RAM_EN             = 1'b1;
                RAM_WE             = 1'b1;
                RAM_ADDR           = clr_cnt;
                {RAM_DIP, RAM_DI}  = CLR_VAL;
                if (clr_cnt == 10'd1023)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (gnt_a) begin
            RAM_EN   = 1'b1;
            RAM_WE   = A_WE;
            RAM_ADDR = A_ADDR;
            RAM_DI   = A_DI;
            RAM_DIP  = A_DIP;
        end else if (gnt_b) begin
            RAM_EN   = 1'b1;
            RAM_WE   = B_WE;
            RAM_ADDR = B_ADDR;
            RAM_DI   = B_DI;
            RAM_DIP  = B_DIP;
        end
    end

    // RAM outputs are shared; RVALID tells each side when they are its own.
    assign RAM_SSR  = 1'b0;
    assign BUSY     = (state == CLEAR);
    assign A_GNT    = gnt_a;
    assign B_GNT    = gnt_b;
    assign A_RVALID = vld_a_p1;
    assign B_RVALID = vld_b_p1;
    assign A_DO     = RAM_DO;
    assign A_DOP    = RAM_DOP;
    assign B_DO     = RAM_DO;
    assign B_DOP    = RAM_DOP;

endmodule

// File: tb/tb_ramb16_s18_arb.sv
// Bench for ramb16_s18_arb: round-robin instance with its own 1Kx18 RAM model
// and a fixed-priority instance sharing the same request stimulus.
module tb_ramb16_s18_arb;

    localparam logic [17:0] CV = 18'h3ABCD;

    logic        CLK = 1'b0, RST_N = 1'b0, CLR = 1'b0;
    logic        A_REQ = 1'b0, A_WE = 1'b0, B_REQ = 1'b0, B_WE = 1'b0;
    logic [9:0]  A_ADDR = '0, B_ADDR = '0;
    logic [15:0] A_DI = '0, B_DI = '0;
    logic [1:0]  A_DIP = '0, B_DIP = '0;

    logic        BUSY, A_GNT, B_GNT, A_RVALID, B_RVALID;
    logic [15:0] A_DO, B_DO, RAM_DI, RAM_DO;
    logic [1:0]  A_DOP, B_DOP, RAM_DIP, RAM_DOP;
    logic        RAM_EN, RAM_WE, RAM_SSR;
    logic [9:0]  RAM_ADDR;

    logic        f_busy, f_ga, f_gb, f_va, f_vb, f_en, f_we, f_ssr;
    logic [15:0] f_do_a, f_do_b, f_di;
    logic [1:0]  f_dop_a, f_dop_b, f_dip;
    logic [9:0]  f_addr;
    logic [15:0] f_ram_do  = '0;
    logic [1:0]  f_ram_dop = '0;

    always #5 CLK = ~CLK;

    ramb16_s18_arb #(.CLR_VAL(CV), .FIXED_PRI(1'b0)) u_rr (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .BUSY(BUSY),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DI(A_DI), .A_DIP(A_DIP),
        .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_DO(A_DO), .A_DOP(A_DOP),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DI(B_DI), .B_DIP(B_DIP),
        .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_DO(B_DO), .B_DOP(B_DOP),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_SSR(RAM_SSR), .RAM_ADDR(RAM_ADDR),
        .RAM_DI(RAM_DI), .RAM_DIP(RAM_DIP), .RAM_DO(RAM_DO), .RAM_DOP(RAM_DOP)
    );

    ramb16_s18_arb #(.FIXED_PRI(1'b1)) u_fp (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .BUSY(f_busy),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DI(A_DI), .A_DIP(A_DIP),
        .A_GNT(f_ga), .A_RVALID(f_va), .A_DO(f_do_a), .A_DOP(f_dop_a),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DI(B_DI), .B_DIP(B_DIP),
        .B_GNT(f_gb), .B_RVALID(f_vb), .B_DO(f_do_b), .B_DOP(f_dop_b),
        .RAM_EN(f_en), .RAM_WE(f_we), .RAM_SSR(f_ssr), .RAM_ADDR(f_addr),
        .RAM_DI(f_di), .RAM_DIP(f_dip), .RAM_DO(f_ram_do), .RAM_DOP(f_ram_dop)
    );

    // Registered-output single-port RAM attached to the round-robin instance
    logic [17:0] mem [1024];
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE)
                mem[RAM_ADDR] <= {RAM_DIP, RAM_DI};
            {RAM_DOP, RAM_DO} <= mem[RAM_ADDR];
        end
    end

    int total = 0, bad = 0;

    // Reference model: memory image, sweep progress, who was served last
    logic [17:0] ref_mem [1024];
    int          sweep_left;
    bit          last_b;
    bit          nv_a, nv_b;
    logic [17:0] nd_a, nd_b;

    bit          e_ga, e_gb, e_va, e_vb, e_busy, e_en, e_we;
    logic [9:0]  e_addr;
    logic [17:0] e_da, e_db;

    logic        o_ga, o_gb, o_va, o_vb, o_busy, o_en, o_we, o_fga, o_fgb;
    logic [9:0]  o_addr;
    logic [17:0] o_da, o_db, o_wd;

    task automatic model_reset();
        sweep_left = 0;
        last_b     = 1'b1;
        nv_a       = 1'b0;
        nv_b       = 1'b0;
    endtask

    task automatic model_step();
        e_va = nv_a; e_vb = nv_b; e_da = nd_a; e_db = nd_b;
        e_busy = (sweep_left > 0);
        e_ga = 0; e_gb = 0; e_en = 0; e_we = 0; e_addr = '0;
        if (e_busy) begin
            e_en = 1; e_we = 1;
            e_addr = 10'(1024 - sweep_left);
            ref_mem[e_addr] = CV;
            sweep_left--;
        end else if (CLR) begin
            sweep_left = 1024;
        end else if (A_REQ && (!B_REQ || last_b)) begin
            e_ga = 1;
        end else if (B_REQ) begin
            e_gb = 1;
        end
        if (e_ga) begin e_en = 1; e_we = A_WE; e_addr = A_ADDR; last_b = 0; end
        if (e_gb) begin e_en = 1; e_we = B_WE; e_addr = B_ADDR; last_b = 1; end
        nv_a = e_ga && !A_WE; nd_a = ref_mem[A_ADDR];
        nv_b = e_gb && !B_WE; nd_b = ref_mem[B_ADDR];
        if (e_ga && A_WE) ref_mem[A_ADDR] = {A_DIP, A_DI};
        if (e_gb && B_WE) ref_mem[B_ADDR] = {B_DIP, B_DI};
    endtask

    // One clock: evaluate and sample mid-cycle, return just after the edge
    task automatic step();
        @(negedge CLK); #1;
        model_step();
        o_ga = A_GNT; o_gb = B_GNT; o_va = A_RVALID; o_vb = B_RVALID;
        o_da = {A_DOP, A_DO}; o_db = {B_DOP, B_DO};
        o_busy = BUSY; o_en = RAM_EN; o_we = RAM_WE; o_addr = RAM_ADDR;
        o_wd = {RAM_DIP, RAM_DI}; o_fga = f_ga; o_fgb = f_gb;
        @(posedge CLK); #1;
    endtask

    task automatic idle_inputs();
        A_REQ = 0; B_REQ = 0; CLR = 0; A_WE = 0; B_WE = 0;
    endtask

    task automatic test_reset();
        RST_N = 0; A_REQ = 1; B_REQ = 1; A_WE = 1; B_WE = 1;
        A_ADDR = 10'd3; A_DI = 16'h0A0A; A_DIP = 2'b10;
        B_ADDR = 10'd4; B_DI = 16'h0B0B; B_DIP = 2'b01;
        #12;
        total++;
        if ({BUSY, A_GNT, B_GNT, A_RVALID, B_RVALID, RAM_EN, RAM_WE, RAM_SSR} !== 8'b0) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=00000000",
                     {BUSY, A_GNT, B_GNT, A_RVALID, B_RVALID, RAM_EN, RAM_WE, RAM_SSR});
        end
        @(negedge CLK); RST_N = 1; #1;
        total++;
        if ({BUSY, A_GNT, B_GNT, RAM_EN, RAM_WE} !== 5'b0) begin
            bad++;
            $display("FAIL reset_release_window got=%b exp=00000",
                     {BUSY, A_GNT, B_GNT, RAM_EN, RAM_WE});
        end
        model_reset();
        @(posedge CLK); #1;
        step();
        total++;
        if ({o_ga, o_gb, o_en, o_we, o_addr} !== {1'b1, 1'b0, 1'b1, 1'b1, 10'd3}) begin
            bad++;
            $display("FAIL reset_first_winner got ga=%b gb=%b en=%b we=%b addr=%0d exp ga=1 gb=0 en=1 we=1 addr=3",
                     o_ga, o_gb, o_en, o_we, o_addr);
        end
        step();
        total++;
        if ({o_ga, o_gb} !== 2'b01) begin
            bad++;
            $display("FAIL reset_second_winner got ga=%b gb=%b exp ga=0 gb=1", o_ga, o_gb);
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        A_REQ = 1; A_WE = 1; A_ADDR = 10'd5; A_DI = 16'h1234; A_DIP = 2'b01;
        step();
        total++;
        if ({o_ga, o_en, o_we, o_addr, o_wd} !== {1'b1, 1'b1, 1'b1, 10'd5, 18'h11234}) begin
            bad++;
            $display("FAIL wr_grant got ga=%b en=%b we=%b addr=%0d wd=%h exp 1 1 1 5 11234",
                     o_ga, o_en, o_we, o_addr, o_wd);
        end
        A_WE = 0;
        step();
        total++;
        if ({o_ga, o_en, o_we, o_va} !== 4'b1100) begin
            bad++;
            $display("FAIL rd_grant got ga=%b en=%b we=%b va=%b exp 1 1 0 0", o_ga, o_en, o_we, o_va);
        end
        A_REQ = 0;
        step();
        total++;
        if ({o_va, o_vb, o_da} !== {1'b1, 1'b0, 18'h11234}) begin
            bad++;
            $display("FAIL rd_data got va=%b vb=%b do=%h exp va=1 vb=0 do=11234", o_va, o_vb, o_da);
        end
        step();
        total++;
        if ({o_va, o_en} !== 2'b00) begin
            bad++;
            $display("FAIL rd_single_pulse got va=%b en=%b exp 0 0", o_va, o_en);
        end
    endtask

    task automatic test_round_robin();
        A_REQ = 1; A_WE = 1; A_ADDR = 10'd10; A_DI = 16'hAAAA; A_DIP = 2'b01;
        step();
        A_REQ = 0; B_REQ = 1; B_WE = 1; B_ADDR = 10'd20; B_DI = 16'h5555; B_DIP = 2'b10;
        step();
        A_REQ = 1; A_WE = 0; B_WE = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin A_REQ = 0; B_REQ = 0; end
            step();
            total++;
            if ({o_ga, o_gb} !== {e_ga, e_gb} || (i < 6 && o_ga !== (i % 2 == 0))) begin
                bad++;
                $display("FAIL rr_grant cyc=%0d got ga=%b gb=%b exp ga=%b gb=%b", i, o_ga, o_gb, e_ga, e_gb);
            end
            if (i > 0) begin
                total++;
                if ({o_va, o_vb} !== {e_va, e_vb} ||
                    (o_va && o_da !== 18'h1AAAA) || (o_vb && o_db !== 18'h25555)) begin
                    bad++;
                    $display("FAIL rr_rdata cyc=%0d got va=%b vb=%b da=%h db=%h exp va=%b vb=%b",
                             i, o_va, o_vb, o_da, o_db, e_va, e_vb);
                end
            end
        end
    endtask

    task automatic test_fixed_pri();
        A_REQ = 1; B_REQ = 1; A_WE = 0; B_WE = 0; A_ADDR = 10'd10; B_ADDR = 10'd20;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) A_REQ = 0;
            step();
            total++;
            if ({o_fga, o_fgb} !== ((i < 4) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL fixed_grant cyc=%0d got ga=%b gb=%b exp %b",
                         i, o_fga, o_fgb, (i < 4) ? 2'b10 : 2'b01);
            end
            total++;
            if ({o_ga, o_gb} !== {e_ga, e_gb}) begin
                bad++;
                $display("FAIL fixed_rr_side cyc=%0d got ga=%b gb=%b exp ga=%b gb=%b",
                         i, o_ga, o_gb, e_ga, e_gb);
            end
        end
        idle_inputs();
        step();
    endtask

    // Shared sweep watcher: counts BUSY cycles, checks sweep writes, stops on first idle cycle
    task automatic run_sweep(input int restart_at, output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 1100; i++) begin
            CLR = (restart_at >= 0 && nbusy == restart_at);
            step();
            if (o_busy) nbusy++;
            total++;
            if (o_busy !== e_busy || (o_busy && ({o_ga, o_gb, o_en, o_we} !== 4'b0011 ||
                o_addr !== e_addr || o_wd !== CV))) begin
                bad++;
                $display("FAIL sweep_cycle n=%0d got busy=%b ga=%b gb=%b en=%b we=%b addr=%0d wd=%h exp busy=%b addr=%0d",
                         nbusy, o_busy, o_ga, o_gb, o_en, o_we, o_addr, o_wd, e_busy, e_addr);
            end
            if (!o_busy && nbusy > 0) break;
        end
        CLR = 0;
    endtask

    task automatic test_clear();
        int nb;
        CLR = 1;
        step();
        total++;
        if ({o_busy, o_ga, o_gb} !== 3'b000) begin
            bad++;
            $display("FAIL clr_start got busy=%b ga=%b gb=%b exp 0 0 0", o_busy, o_ga, o_gb);
        end
        CLR = 0; B_REQ = 1; B_WE = 0; B_ADDR = 10'h3FF;
        run_sweep(-1, nb);
        total++;
        if (nb !== 1024 || o_gb !== 1'b1) begin
            bad++;
            $display("FAIL clr_length got busy_cycles=%0d gb=%b exp busy_cycles=1024 gb=1", nb, o_gb);
        end
        B_REQ = 0;
        step();
        total++;
        if ({o_vb, o_db} !== {1'b1, 18'h3ABCD}) begin
            bad++;
            $display("FAIL clr_readback got vb=%b do=%h exp vb=1 do=3abcd", o_vb, o_db);
        end
    endtask

    task automatic test_clr_collision();
        int nb;
        CLR = 1; B_REQ = 1; B_WE = 0; B_ADDR = 10'd7;
        step();
        total++;
        if ({o_gb, o_en, o_busy} !== 3'b000) begin
            bad++;
            $display("FAIL clr_beats_req got gb=%b en=%b busy=%b exp 0 0 0", o_gb, o_en, o_busy);
        end
        run_sweep(500, nb);
        total++;
        if (nb !== 1024 || o_gb !== 1'b1) begin
            bad++;
            $display("FAIL clr_no_restart got busy_cycles=%0d gb=%b exp busy_cycles=1024 gb=1", nb, o_gb);
        end
        B_REQ = 0;
        step();
        total++;
        if ({o_vb, o_db} !== {1'b1, CV}) begin
            bad++;
            $display("FAIL clr_collision_read got vb=%b do=%h exp vb=1 do=%h", o_vb, o_db, CV);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            if (!A_REQ && $urandom_range(0, 3) != 0) begin
                A_REQ = 1; A_WE = $urandom_range(0, 1) == 1; A_ADDR = 10'($urandom_range(0, 15));
                A_DI = 16'($urandom); A_DIP = 2'($urandom);
            end
            if (!B_REQ && $urandom_range(0, 3) != 0) begin
                B_REQ = 1; B_WE = $urandom_range(0, 1) == 1; B_ADDR = 10'($urandom_range(0, 15));
                B_DI = 16'($urandom); B_DIP = 2'($urandom);
            end
            step();
            total++;
            if ({o_ga, o_gb, o_va, o_vb, o_en, o_we} !== {e_ga, e_gb, e_va, e_vb, e_en, e_we} ||
                (e_en && o_addr !== e_addr) ||
                (e_va && o_da !== e_da) || (e_vb && o_db !== e_db)) begin
                bad++;
                $display("FAIL rand cyc=%0d got ga%b gb%b va%b vb%b en%b we%b addr=%0d da=%h db=%h exp ga%b gb%b va%b vb%b en%b we%b addr=%0d da=%h db=%h",
                         i, o_ga, o_gb, o_va, o_vb, o_en, o_we, o_addr, o_da, o_db,
                         e_ga, e_gb, e_va, e_vb, e_en, e_we, e_addr, e_da, e_db);
            end
            if (e_ga) A_REQ = 0;
            if (e_gb) B_REQ = 0;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_sweep();
        int nb;
        nb = 0;
        CLR = 1;
        step();
        CLR = 0;
        for (int i = 0; i < 400 && nb < 300; i++) begin
            step();
            if (o_busy) nb++;
        end
        #1;
        total++;
        if ({BUSY, RAM_EN, RAM_ADDR} !== {1'b1, 1'b1, 10'd300}) begin
            bad++;
            $display("FAIL mid_sweep_pos got busy=%b en=%b addr=%0d exp 1 1 300", BUSY, RAM_EN, RAM_ADDR);
        end
        RST_N = 0;
        #1;
        total++;
        if ({BUSY, RAM_EN, RAM_WE, A_RVALID, B_RVALID} !== 5'b0) begin
            bad++;
            $display("FAIL mid_sweep_reset got busy=%b en=%b we=%b va=%b vb=%b exp all 0",
                     BUSY, RAM_EN, RAM_WE, A_RVALID, B_RVALID);
        end
        A_REQ = 1; A_WE = 1; A_ADDR = 10'd5; A_DI = 16'hC3C3; A_DIP = 2'b10;
        @(negedge CLK); RST_N = 1;
        model_reset();
        @(posedge CLK); #1;
        step();
        total++;
        if ({o_ga, o_busy, o_en, o_we} !== 4'b1011) begin
            bad++;
            $display("FAIL after_reset_grant got ga=%b busy=%b en=%b we=%b exp 1 0 1 1", o_ga, o_busy, o_en, o_we);
        end
        A_WE = 0;
        step();
        A_REQ = 0;
        step();
        total++;
        if ({o_va, o_da} !== {1'b1, 18'h2C3C3}) begin
            bad++;
            $display("FAIL after_reset_read got va=%b do=%h exp va=1 do=2c3c3", o_va, o_da);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_pri();
        test_clear();
        test_clr_collision();
        test_random();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/ramb16_s18_arb.md
RAMB16_S18_ARB -- requirements
Module: ramb16_s18_arb

Interface
REQ-001 Parameter: CLR_VAL, default 18'h0, value written to every word ({parity[1:0], data[15:0]}) during a clear sweep.
REQ-002 Parameter: FIXED_PRI, default 0, where 0 = round-robin and 1 = requester A always wins.
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 CLR  in  1  single-cycle pulse that starts a clear sweep of all 1024 words.
REQ-006 BUSY  out  1  high while the clear sweep runs.
REQ-007 A_REQ, B_REQ  in  1  access request, held with stable fields until granted.
REQ-008 A_WE, B_WE  in  1  1 = write, 0 = read.
REQ-009 A_ADDR, B_ADDR  in  10  word address.
REQ-010 A_DI, B_DI  in  16 / A_DIP, B_DIP  in  2  write data and write parity.
REQ-011 A_GNT, B_GNT  out  1  combinational grant; the access is performed at this CLK edge.
REQ-012 A_RVALID, B_RVALID  out  1  read data valid, asserted one cycle after a read grant.
REQ-013 A_DO, B_DO  out  16 / A_DOP, B_DOP  out  2  read data and parity, routed from the RAM outputs.
REQ-014 RAM_EN, RAM_WE, RAM_SSR  out  1 / RAM_ADDR  out  10 / RAM_DI  out  16 / RAM_DIP  out  2  drive to the 1Kx18 single-port RAM.
REQ-015 RAM_DO  in  16 / RAM_DOP  in  2  registered RAM outputs, valid one cycle after an EN edge.

Function
REQ-016 RAM_SSR shall be tied to 0.
REQ-017 The block shall have exactly two states: IDLE (serve requesters) and CLEAR (sweep).
- IDLE -> CLEAR on CLR=1.
- CLEAR -> IDLE after the cycle that writes address 1023.
REQ-018 In IDLE with exactly one REQ high, that requester shall be granted in the same cycle.
REQ-019 In IDLE with both REQ high, the winner shall be:
- FIXED_PRI=1: A.
- FIXED_PRI=0: the requester not granted most recently; after reset, A.
REQ-020 The last-granted flag shall update only on a grant cycle.
REQ-021 At most one GNT shall be high per cycle; GNT shall be 0 when the matching REQ is 0.
REQ-022 On a grant, the block shall drive RAM_EN=1 and RAM_WE/ADDR/DI/DIP from the winner; with no grant, RAM_EN=0 and RAM_WE=0.
REQ-023 A registered owner tag shall assert the winner's RVALID for exactly one cycle following a read grant; RVALID shall be 0 after a write grant.
REQ-024 X_DO/X_DOP shall equal RAM_DO/RAM_DOP whenever X_RVALID=1; they are don't-care otherwise.
REQ-025 Back-to-back grants shall be allowed every cycle (throughput 1 access/cycle), and read latency shall be 1 cycle.
REQ-026 In CLEAR:
- BUSY=1 and both GNT=0.
- A 10-bit counter starts at 0 and increments by 1 per cycle.
- Each cycle: RAM_EN=1, RAM_WE=1, RAM_ADDR=counter, {RAM_DIP,RAM_DI}=CLR_VAL.
- The sweep lasts 1024 cycles.
REQ-027 CLR received while in CLEAR shall be ignored; no restart.
REQ-028 CLR and REQ in the same IDLE cycle: CLR wins, no grant that cycle, and the requester keeps REQ high.
REQ-029 Read granted in the cycle before CLR: its RVALID shall still assert on the following cycle.
REQ-030 After the sweep, the first IDLE cycle shall grant normally; the round-robin flag is unchanged by CLEAR.

Reset
REQ-031 RST_N=0 shall immediately force:
- state=IDLE, counter=0, last-granted=B (so A wins first).
- owner tag cleared.
- BUSY=0, RVALID both 0, RAM_EN=0, RAM_WE=0.
REQ-032 Reset asserted mid-sweep shall abort the sweep without completing it; memory contents are then undefined by this block.
REQ-033 All outputs shall remain at their reset values until the first CLK edge after RST_N rises.

Verification
REQ-034 A writes 0x1234 parity 2'b01 at address 5, then reads address 5 -> A_GNT both cycles; A_RVALID one cycle after the read with A_DO=0x1234, A_DOP=2'b01.
REQ-035 FIXED_PRI=0, A and B both reading continuously from 10 and 20 -> grants alternate A,B,A,B starting with A; each RVALID carries that requester's data.
REQ-036 FIXED_PRI=1, both requesting for 4 cycles -> A_GNT for all 4 cycles and B_GNT=0; B is granted the cycle after A drops.
REQ-037 CLR pulse with CLR_VAL=18'h3ABCD -> BUSY high for exactly 1024 cycles; a read of address 0x3FF afterwards returns DO=0xABCD, DOP=2'b11; a B_REQ held during the sweep is granted on the first IDLE cycle.
REQ-038 RST_N pulled low at sweep address 300 -> BUSY, RAM_EN and RVALID drop immediately; after release, A_REQ is granted on the first cycle.
REQ-039 CLR and B_REQ in the same cycle, then a second CLR mid-sweep -> no B grant that cycle, and BUSY lasts exactly 1024 cycles with no restart.
